spi_master: RTL and testbench

//  SPI mode-0 master (CPOL=0, CPHA=0, MSB first): the transmitting end of the link that spi_slave terminates.

---
 rtl/spi_master.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_spi_master.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// SPI mode-0 master (CPOL=0, CPHA=0, MSB first).
// Bytes arrive through a one-entry skid buffer and are serialised onto
// sclk/mosi inside a cs_n frame. Each byte sampled on miso is returned as a
// one-cycle strobe. The buffer lets the next byte be loaded on the same edge
// that ends the current one, so consecutive bytes produce no sclk gap.
module spi_master #(
  parameter int CLK_DIV  = 3,  // clk_i cycles per sclk half-period (>=2)
  parameter int CS_SETUP = 2,  // cycles from cs_n fall to start of first low half
  parameter int CS_HOLD  = 2   // cycles from last sclk fall to cs_n rise
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       tx_byte_vld_i,
  input  logic [7:0] tx_byte_data_i,
  input  logic       tx_byte_last_i,
  output logic       tx_byte_rdy_o,
  output logic       spi_sclk_o,
  output logic       spi_mosi_o,
  output logic       spi_cs_n_o,
  input  logic       spi_miso_i,
  output logic       rx_byte_vld_o,
  output logic [7:0] rx_byte_data_o,
  output logic       busy_o
);

  // One counter serves as sclk divider in SHIFT and as wait timer in SETUP/HOLD.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  localparam int CNT_W = $clog2(max3(CLK_DIV, CS_SETUP, CS_HOLD) + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_STALL = 3'd3,
    ST_HOLD  = 3'd4
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic [CNT_W-1:0] cnt_r;
  logic [3:0]       bit_cnt_r;
  logic [7:0]       tx_shift_r;
  logic [7:0]       rx_shift_r;
  logic             cur_last_r;
  logic             buf_full_r;
  logic [7:0]       buf_data_r;
  logic             buf_last_r;
  logic             sclk_r;
  logic             mosi_r;
  logic             cs_n_r;
  logic             rx_vld_r;
  logic [7:0]       rx_data_r;
  logic             rdy_r;
  logic             busy_r;

  logic             tick_s;
  logic             load_s;
  logic             start_s;
  logic             rise_s;
  logic             fall_s;
  logic             byte_done_s;
  logic             hold_done_s;
  logic             fire_s;
  logic             buf_full_next_s;

  // Next-state and control strobes; a load always empties the buffer.
  always_comb begin
    state_next_s = state_r;
    tick_s       = 1'b0;
    load_s       = 1'b0;
    start_s      = 1'b0;
    rise_s       = 1'b0;
    fall_s       = 1'b0;
    byte_done_s  = 1'b0;
    hold_done_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (buf_full_r) begin
          load_s       = 1'b1;
          start_s      = 1'b1;
          state_next_s = ST_SETUP;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (cnt_r == SETUP_LAST) begin
          state_next_s = ST_SHIFT;
        end else begin
          state_next_s = ST_SETUP;
        end
      end
      ST_SHIFT: begin
        tick_s = (cnt_r == DIV_LAST);
        if (tick_s && !sclk_r) begin
          rise_s = 1'b1;
        end else if (tick_s && sclk_r) begin
          fall_s = 1'b1;
          if (bit_cnt_r == 4'd8) begin
            byte_done_s = 1'b1;
            if (cur_last_r) begin
              state_next_s = ST_HOLD;
            end else if (buf_full_r) begin
              load_s       = 1'b1;
              state_next_s = ST_SHIFT;
            end else begin
              state_next_s = ST_STALL;
            end
          end else begin
            state_next_s = ST_SHIFT;
          end
        end else begin
          state_next_s = ST_SHIFT;
        end
      end
      ST_STALL: begin
        if (buf_full_r) begin
          load_s       = 1'b1;
          state_next_s = ST_SHIFT;
        end else begin
          state_next_s = ST_STALL;
        end
      end
      ST_HOLD: begin
        if (cnt_r == HOLD_LAST) begin
          hold_done_s  = 1'b1;
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_HOLD;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Buffer accepts only when empty, so rdy is simply the inverse of full.
  always_comb begin
    fire_s          = tx_byte_vld_i && rdy_r;
    buf_full_next_s = (buf_full_r && !load_s) || fire_s;
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Divider/wait counter: cleared on every state entry and on each sclk toggle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_r <= CNT_ZERO;
    end else if (state_next_s != state_r) begin
      cnt_r <= CNT_ZERO;
    end else if (state_r == ST_SHIFT) begin
      cnt_r <= tick_s ? CNT_ZERO : (cnt_r + CNT_ONE);
    end else if ((state_r == ST_SETUP) || (state_r == ST_HOLD)) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= CNT_ZERO;
    end
  end

  // Skid buffer holding one {data,last} entry plus registered rdy/busy.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      buf_full_r <= 1'b0;
      buf_data_r <= 8'h00;
      buf_last_r <= 1'b0;
      rdy_r      <= 1'b1;
      busy_r     <= 1'b0;
    end else begin
      buf_full_r <= buf_full_next_s;
      if (fire_s) begin
        buf_data_r <= tx_byte_data_i;
        buf_last_r <= tx_byte_last_i;
      end else begin
        buf_data_r <= buf_data_r;
        buf_last_r <= buf_last_r;
      end
      rdy_r  <= !buf_full_next_s;
      busy_r <= (state_next_s != ST_IDLE) || buf_full_next_s;
    end
  end

  // Transmit path: load presents bit7 at once, later bits change on sclk falls.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tx_shift_r <= 8'h00;
      mosi_r     <= 1'b0;
      cur_last_r <= 1'b0;
    end else if (load_s) begin
      tx_shift_r <= buf_data_r;
      mosi_r     <= buf_data_r[7];
      cur_last_r <= buf_last_r;
    end else if (fall_s && !byte_done_s) begin
      tx_shift_r <= {tx_shift_r[6:0], 1'b0};
      mosi_r     <= tx_shift_r[6];
    end else if (hold_done_s) begin
      mosi_r     <= 1'b0;
    end else begin
      tx_shift_r <= tx_shift_r;
      mosi_r     <= mosi_r;
    end
  end

  // sclk, cs_n and bit counter; cs_n only moves at frame start and end.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sclk_r    <= 1'b0;
      cs_n_r    <= 1'b1;
      bit_cnt_r <= 4'd0;
    end else begin
      if (rise_s) begin
        sclk_r <= 1'b1;
      end else if (fall_s) begin
        sclk_r <= 1'b0;
      end else begin
        sclk_r <= sclk_r;
      end
      if (start_s) begin
        cs_n_r <= 1'b0;
      end else if (hold_done_s) begin
        cs_n_r <= 1'b1;
      end else begin
        cs_n_r <= cs_n_r;
      end
      if (load_s || byte_done_s) begin
        bit_cnt_r <= 4'd0;
      end else if (rise_s) begin
        bit_cnt_r <= bit_cnt_r + 4'd1;
      end else begin
        bit_cnt_r <= bit_cnt_r;
      end
    end
  end

  // Receive path: sample miso on rising sclk, publish on the byte's last fall.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rx_shift_r <= 8'h00;
      rx_vld_r   <= 1'b0;
      rx_data_r  <= 8'h00;
    end else begin
      if (rise_s) begin
        rx_shift_r <= {rx_shift_r[6:0], spi_miso_i};
      end else begin
        rx_shift_r <= rx_shift_r;
      end
      rx_vld_r <= byte_done_s;
      if (byte_done_s) begin
        rx_data_r <= rx_shift_r;
      end else begin
        rx_data_r <= rx_data_r;
      end
    end
  end

  assign tx_byte_rdy_o  = rdy_r;
  assign spi_sclk_o     = sclk_r;
  assign spi_mosi_o     = mosi_r;
  assign spi_cs_n_o     = cs_n_r;
  assign rx_byte_vld_o  = rx_vld_r;
  assign rx_byte_data_o = rx_data_r;
  assign busy_o         = busy_r;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: an SPI-side monitor rebuilds mosi bytes,
// measures sclk phases and cs_n setup/hold, and collects rx strobes; miso is
// tied low, looped back, or driven by a tiny mode-0 slave that answers 0x6E.
`timescale 1ns/1ps
module tb_spi_master;
  localparam int CLK_DIV  = 3;
  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_vld, tx_last, tx_rdy;
  logic [7:0] tx_data;
  logic       sclk, mosi, cs_n, miso;
  logic       rx_vld, busy;
  logic [7:0] rx_data;
  logic [1:0] miso_mode;
  logic [7:0] slv_byte = 8'h6E;

  spi_master #(.CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .tx_byte_vld_i(tx_vld), .tx_byte_data_i(tx_data), .tx_byte_last_i(tx_last),
    .tx_byte_rdy_o(tx_rdy),
    .spi_sclk_o(sclk), .spi_mosi_o(mosi), .spi_cs_n_o(cs_n), .spi_miso_i(miso),
    .rx_byte_vld_o(rx_vld), .rx_byte_data_o(rx_data), .busy_o(busy)
  );

  always #2.5 clk = ~clk;

  // monitor state
  int         rises = 0, gaps = 0, hi_bad = 0, frames = 0;
  int         ph_len = 0, setup_cnt = 0, hold_cnt = 0;
  int         last_setup = 0, last_hold = 0;
  logic       setup_pend = 1'b0, prev_sclk = 1'b0, prev_cs = 1'b1;
  logic [7:0] mosi_acc = 8'h00;
  logic [3:0] acc_cnt = 4'd0;
  logic [7:0] mosi_q[$];
  logic [7:0] rx_q[$];

  assign miso = (miso_mode == 2'd1) ? mosi :
                (miso_mode == 2'd2) ? slv_byte[3'd7 - acc_cnt[2:0]] : 1'b0;

  // SPI-side monitor, sampled on the falling clk edge
  always @(negedge clk) begin
    if (prev_cs && !cs_n) begin
      frames++; setup_cnt = 1; setup_pend = 1'b1;
    end else if (!cs_n && setup_pend && !sclk) begin
      setup_cnt++;
    end
    if (!prev_cs && cs_n) last_hold = hold_cnt;
    if (!prev_sclk && sclk) begin
      rises++;
      if (setup_pend) begin
        last_setup = setup_cnt; setup_pend = 1'b0;
      end else if (ph_len > CLK_DIV) begin
        gaps++;
      end
      mosi_acc = {mosi_acc[6:0], mosi};
      acc_cnt = acc_cnt + 4'd1;
      if (acc_cnt == 4'd8) begin
        mosi_q.push_back(mosi_acc); acc_cnt = 4'd0;
      end
      ph_len = 1;
    end else if (prev_sclk && !sclk) begin
      if (ph_len != CLK_DIV) hi_bad++;
      ph_len = 1; hold_cnt = 1;
    end else begin
      ph_len++; hold_cnt++;
    end
    if (cs_n) acc_cnt = 4'd0;
    if (rx_vld) rx_q.push_back(rx_data);
    prev_sclk = sclk; prev_cs = cs_n;
  end

  int total_cnt = 0, bad_cnt = 0, throttle = 0;
  int r0, g0, h0, f0, mq0, rq0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    r0 = rises; g0 = gaps; h0 = hi_bad; f0 = frames;
    mq0 = mosi_q.size(); rq0 = rx_q.size();
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    tx_vld = 1'b1; tx_data = d; tx_last = l;
    while (!tx_rdy && n < 2000) begin
      @(negedge clk); n++; throttle++;
    end
    chk("send_timeout", (n < 2000), 1);
    @(negedge clk);
    tx_vld = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || !cs_n) && n < 5000) begin
      @(negedge clk); n++;
    end
    chk("idle_timeout", (n < 5000), 1);
    repeat (2) @(negedge clk);
  endtask

  // common frame checks: byte count, sclk rises, clean high phases, one frame
  task automatic chk_frame(input string t, input int nbytes, input int ngaps);
    chk({t, "_nbytes"}, mosi_q.size() - mq0, nbytes);
    chk({t, "_rises"}, rises - r0, 8 * nbytes);
    chk({t, "_gaps"}, gaps - g0, ngaps);
    chk({t, "_hiphase"}, hi_bad - h0, 0);
    chk({t, "_frames"}, frames - f0, 1);
  endtask

  logic [7:0] t4_vec [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h5A, 8'hA5, 8'hF0, 8'h0F};

  initial begin
    int n, bad;
    tx_vld = 1'b0; tx_data = 8'h00; tx_last = 1'b0; miso_mode = 2'd0;
    repeat (3) @(negedge clk);
    chk("rst_sclk", sclk, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_cs_n", cs_n, 1);
    chk("rst_rx_vld", rx_vld, 0);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_rdy", tx_rdy, 1);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // T1: back-to-back 0x2A, 0x2B(last), miso low
    snap();
    send_byte(8'h2A, 1'b0);
    send_byte(8'h2B, 1'b1);
    wait_done();
    chk_frame("t1", 2, 0);
    chk("t1_b0", mosi_q[mq0], 8'h2A);
    chk("t1_b1", mosi_q[mq0 + 1], 8'h2B);
    chk("t1_setup", last_setup, CS_SETUP + CLK_DIV);
    chk("t1_hold", last_hold, CS_HOLD);
    chk("t1_rxn", rx_q.size() - rq0, 2);
    chk("t1_rx0", rx_q[rq0], 8'h00);

    // T2: loopback
    miso_mode = 2'd1;
    snap();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h3C, 1'b1);
    wait_done();
    chk_frame("t2", 2, 0);
    chk("t2_rxn", rx_q.size() - rq0, 2);
    chk("t2_rx0", rx_q[rq0], 8'hA5);
    chk("t2_rx1", rx_q[rq0 + 1], 8'h3C);

    // T3: source idle for 40 cycles after the first byte -> stall
    miso_mode = 2'd0;
    snap();
    send_byte(8'h55, 1'b0);
    n = 0;
    while (rx_q.size() == rq0 && n < 2000) begin
      @(negedge clk); n++;
    end
    chk("t3_byte_timeout", (n < 2000), 1);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (sclk || cs_n) bad++;
    end
    chk("t3_stall_lines", bad, 0);
    send_byte(8'hAA, 1'b1);
    wait_done();
    chk_frame("t3", 2, 1);
    chk("t3_b0", mosi_q[mq0], 8'h55);
    chk("t3_b1", mosi_q[mq0 + 1], 8'hAA);

    // T4: 8 bytes with vld held high, last on the 8th
    snap();
    throttle = 0;
    for (int i = 0; i < 8; i++) send_byte(t4_vec[i], (i == 7));
    wait_done();
    chk_frame("t4", 8, 0);
    chk("t4_throttled", (throttle > 0), 1);
    bad = 0;
    for (int i = 0; i < 8; i++) if (mosi_q[mq0 + i] !== t4_vec[i]) bad++;
    chk("t4_bytes", bad, 0);

    // T5: reset after 5th rise of 0xFF
    snap();
    send_byte(8'hFF, 1'b1);
    n = 0;
    while (rises - r0 < 5 && n < 2000) begin
      @(negedge clk); n++;
    end
    chk("t5_rise_timeout", (n < 2000), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_cs_n", cs_n, 1);
    chk("t5_sclk", sclk, 0);
    chk("t5_mosi", mosi, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("t5_no_rx", rx_q.size() - rq0, 0);
    snap();
    send_byte(8'hC3, 1'b1);
    wait_done();
    chk_frame("t5", 1, 0);
    chk("t5_b0", mosi_q[mq0], 8'hC3);
    chk("t5_rxn", rx_q.size() - rq0, 1);

    // T6: mode-0 slave answering 0x6E
    miso_mode = 2'd2;
    snap();
    send_byte(8'h2A, 1'b0);
    send_byte(8'h2B, 1'b1);
    wait_done();
    chk_frame("t6", 2, 0);
    chk("t6_slv_b0", mosi_q[mq0], 8'h2A);
    chk("t6_slv_b1", mosi_q[mq0 + 1], 8'h2B);
    chk("t6_rxn", rx_q.size() - rq0, 2);
    chk("t6_rx0", rx_q[rq0], 8'h6E);
    chk("t6_rx1", rx_q[rq0 + 1], 8'h6E);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end
endmodule
